// File: rtl/ranked_time_board_pkg.sv
// Shared encodings for the ranked time board.
// Mode select, display board code and FSM state values.
package ranked_time_pkg;

    localparam logic [1:0] MODE_SLOW = 2'b01;
    localparam logic [1:0] MODE_FAST = 2'b10;

    localparam logic [1:0] SOF_FAST = 2'b11;
    localparam logic [1:0] SOF_SLOW = 2'b01;
    localparam logic [1:0] SOF_NONE = 2'b00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIND   = 2'd1,
        INSERT = 2'd2
    } fsm_e;

endpackage

// File: rtl/ranked_time_board_if.sv
// Sample handshake and result bundle of the ranked time board.
// The master side offers times; the slave side is the board.
interface ranked_time_board_if #(
    parameter int TIME_W = 22,
    parameter int DEPTH  = 3
);
    localparam int RANK_W = $clog2(DEPTH + 1);

    logic [TIME_W-1:0] time_in;
    logic              time_valid;
    logic              time_ready;
    logic [1:0]        stopwatch_mode;
    logic              clear;
    logic              result_valid;
    logic [RANK_W-1:0] result_rank;
    logic [DEPTH-1:0]  sound_pulse;

    modport master (
        output time_in,
        output time_valid,
        output stopwatch_mode,
        output clear,
        input  time_ready,
        input  result_valid,
        input  result_rank,
        input  sound_pulse
    );

    modport slave (
        input  time_in,
        input  time_valid,
        input  stopwatch_mode,
        input  clear,
        output time_ready,
        output result_valid,
        output result_rank,
        output sound_pulse
    );

endinterface

// File: rtl/ranked_time_board_rank_board.sv
// One sorted board of DEPTH times with per-slot valid bits.
// DESCENDING=1 keeps longest first, otherwise shortest first.
module rank_board #(
    parameter int TIME_W     = 22,
    parameter int DEPTH      = 3,
    parameter bit DESCENDING = 1'b0,
    parameter int RANK_W     = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          ins,
    input  logic [TIME_W-1:0]             cand,
    input  logic [RANK_W-1:0]             pos,
    output logic [DEPTH-1:0][TIME_W-1:0]  entry,
    output logic [DEPTH-1:0]              valid,
    output logic [RANK_W-1:0]             ahead
);

    logic [DEPTH-1:0][TIME_W-1:0] nxt_e;
    logic [DEPTH-1:0]             nxt_v;

    // Ties count the stored entry as ahead so equal times keep arrival order.
    always_comb begin
        ahead = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                if (DESCENDING ? (entry[i] >= cand) : (entry[i] <= cand))
                    ahead = ahead + RANK_W'(1);
            end
        end
    end

    always_comb begin
        nxt_e = entry;
        nxt_v = valid;
        if (pos == '0) begin
            nxt_e[0] = cand;
            nxt_v[0] = 1'b1;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (RANK_W'(i) == pos) begin
                nxt_e[i] = cand;
                nxt_v[i] = 1'b1;
            end else if (RANK_W'(i) > pos) begin
                nxt_e[i] = entry[i-1];
                nxt_v[i] = valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            entry <= '0;
            valid <= '0;
        end else if (ins) begin
            entry <= nxt_e;
            valid <= nxt_v;
        end
    end

endmodule

// File: rtl/ranked_time_board.sv
// Fast/slow leaderboard: accepts times, ranks them into two boards,
// pulses per-rank sound strobes and drives the display mux.
module ranked_time_board
    import ranked_time_pkg::*;
#(
    parameter int TIME_W = 22,
    parameter int DEPTH  = 3,
    parameter int RANK_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    ranked_time_board_if.slave bus,
    input  logic               disp_board,
    input  logic [RANK_W-1:0]  disp_rank,
    output logic [TIME_W-1:0]  leaderboard_number,
    output logic               disp_entry_valid,
    output logic [DEPTH-1:0]   leaderboard_LED,
    output logic [1:0]         slow_or_fast
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_FIND   = FIND;
    localparam logic [1:0] S_INSERT = INSERT;

    logic [1:0]        state;
    logic [TIME_W-1:0] cand;
    logic              sel_slow;
    logic [RANK_W-1:0] pos_q;

    logic [DEPTH-1:0][TIME_W-1:0] fast_e, slow_e;
    logic [DEPTH-1:0]             fast_v, slow_v;
    logic [RANK_W-1:0]            fast_ahead, slow_ahead;

    logic             mode_ok, accept, drop, placed, do_ins;
    logic [DEPTH-1:0] hot;

    assign mode_ok = (bus.stopwatch_mode == MODE_SLOW) ||
                     (bus.stopwatch_mode == MODE_FAST);
    assign accept  = (state == S_IDLE) && bus.time_valid && !bus.clear &&
                     mode_ok && (bus.time_in != '0);
    assign drop    = (state == S_IDLE) && bus.time_valid && !bus.clear &&
                     !accept;
    assign placed  = pos_q < RANK_W'(DEPTH);
    assign do_ins  = (state == S_INSERT) && !bus.clear && placed;

    assign bus.time_ready = (state == S_IDLE);

    always_comb begin
        hot = '0;
        for (int i = 0; i < DEPTH; i++)
            if (RANK_W'(i) == pos_q) hot[i] = 1'b1;
    end

    rank_board #(
        .TIME_W(TIME_W), .DEPTH(DEPTH),
        .DESCENDING(1'b0), .RANK_W(RANK_W)
    ) u_fast (
        .clk(clk), .rst_n(rst_n), .clear(bus.clear),
        .ins(do_ins && !sel_slow), .cand(cand), .pos(pos_q),
        .entry(fast_e), .valid(fast_v), .ahead(fast_ahead)
    );

    rank_board #(
        .TIME_W(TIME_W), .DEPTH(DEPTH),
        .DESCENDING(1'b1), .RANK_W(RANK_W)
    ) u_slow (
        .clk(clk), .rst_n(rst_n), .clear(bus.clear),
        .ins(do_ins && sel_slow), .cand(cand), .pos(pos_q),
        .entry(slow_e), .valid(slow_v), .ahead(slow_ahead)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            cand             <= '0;
            sel_slow         <= 1'b0;
            pos_q            <= '0;
            bus.result_valid <= 1'b0;
            bus.result_rank  <= '0;
            bus.sound_pulse  <= '0;
        end else begin
            bus.result_valid <= 1'b0;
            bus.result_rank  <= '0;
            bus.sound_pulse  <= '0;
            if (bus.clear) begin
                state <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (accept) begin
                            cand     <= bus.time_in;
                            sel_slow <= (bus.stopwatch_mode == MODE_SLOW);
                            state    <= S_FIND;
                        end else if (drop) begin
                            bus.result_valid <= 1'b1;
                        end
                    end
                    S_FIND: begin
                        pos_q <= sel_slow ? slow_ahead : fast_ahead;
                        state <= S_INSERT;
                    end
                    S_INSERT: begin
                        bus.result_valid <= 1'b1;
                        if (placed) begin
                            bus.result_rank <= pos_q + RANK_W'(1);
                            bus.sound_pulse <= hot;
                        end
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    logic [DEPTH-1:0][TIME_W-1:0] sh_e;
    logic [DEPTH-1:0]             sh_v;

    assign sh_e = disp_board ? slow_e : fast_e;
    assign sh_v = disp_board ? slow_v : fast_v;

    // Out-of-range ranks blank the whole display path.
    always_comb begin
        leaderboard_number = '0;
        disp_entry_valid   = 1'b0;
        leaderboard_LED    = '0;
        slow_or_fast       = SOF_NONE;
        if (disp_rank != '0 && disp_rank <= RANK_W'(DEPTH)) begin
            slow_or_fast = disp_board ? SOF_SLOW : SOF_FAST;
            for (int i = 0; i < DEPTH; i++) begin
                if (RANK_W'(i) < disp_rank) leaderboard_LED[i] = 1'b1;
                if (RANK_W'(i + 1) == disp_rank) begin
                    disp_entry_valid = sh_v[i];
                    if (sh_v[i]) leaderboard_number = sh_e[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_ranked_time_board.sv
// Directed and randomized checks of ranked_time_board against a
// queue-based leaderboard model.
module tb_ranked_time_board;
    import ranked_time_pkg::*;

    localparam int TIME_W = 22;
    localparam int DEPTH  = 3;
    localparam int RANK_W = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic disp_board = 1'b0;
    logic [RANK_W-1:0] disp_rank = '0;
    logic [TIME_W-1:0] leaderboard_number;
    logic disp_entry_valid;
    logic [DEPTH-1:0] leaderboard_LED;
    logic [1:0] slow_or_fast;

    int checks = 0;
    int errors = 0;

    logic [TIME_W-1:0] fast_q[$];
    logic [TIME_W-1:0] slow_q[$];

    ranked_time_board_if #(.TIME_W(TIME_W), .DEPTH(DEPTH)) bus ();

    ranked_time_board #(.TIME_W(TIME_W), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .disp_board(disp_board),
        .disp_rank(disp_rank),
        .leaderboard_number(leaderboard_number),
        .disp_entry_valid(disp_entry_valid),
        .leaderboard_LED(leaderboard_LED),
        .slow_or_fast(slow_or_fast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Place a time on the model board; returns the zero-based slot or DEPTH.
    function automatic int model_place(input bit slow, input logic [TIME_W-1:0] t);
        int p;
        p = 0;
        if (slow) begin
            foreach (slow_q[i]) if (slow_q[i] >= t) p++;
            if (p < DEPTH) begin
                slow_q.insert(p, t);
                if (slow_q.size() > DEPTH) void'(slow_q.pop_back());
            end
        end else begin
            foreach (fast_q[i]) if (fast_q[i] <= t) p++;
            if (p < DEPTH) begin
                fast_q.insert(p, t);
                if (fast_q.size() > DEPTH) void'(fast_q.pop_back());
            end
        end
        return p;
    endfunction

    task automatic check_display(input string tag);
        logic [TIME_W-1:0] en;
        logic ev;
        logic [DEPTH-1:0] el;
        logic [1:0] es;
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < (1 << RANK_W); r++) begin
                disp_board = b[0];
                disp_rank = RANK_W'(r);
                #1;
                en = '0; ev = 1'b0; el = '0; es = SOF_NONE;
                if (r >= 1 && r <= DEPTH) begin
                    es = b ? SOF_SLOW : SOF_FAST;
                    el = DEPTH'((1 << r) - 1);
                    if (b == 1 && r <= slow_q.size()) begin
                        en = slow_q[r-1]; ev = 1'b1;
                    end
                    if (b == 0 && r <= fast_q.size()) begin
                        en = fast_q[r-1]; ev = 1'b1;
                    end
                end
                chk($sformatf("%s_num_b%0d_r%0d", tag, b, r), 32'(leaderboard_number), 32'(en));
                chk($sformatf("%s_ev_b%0d_r%0d", tag, b, r), 32'(disp_entry_valid), 32'(ev));
                chk($sformatf("%s_led_b%0d_r%0d", tag, b, r), 32'(leaderboard_LED), 32'(el));
                chk($sformatf("%s_sof_b%0d_r%0d", tag, b, r), 32'(slow_or_fast), 32'(es));
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bus.time_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready_wait"}, 32'(bus.time_ready), 32'd1);
    endtask

    // Offer one sample; optionally keep time_valid high while the block is busy.
    task automatic sample(input string tag, input logic [TIME_W-1:0] t,
                          input logic [1:0] m, input bit spam);
        bit acc;
        int p;
        int er;
        logic [DEPTH-1:0] es;
        acc = (m == MODE_SLOW || m == MODE_FAST) && t != '0;
        wait_ready(tag);
        bus.time_in = t;
        bus.stopwatch_mode = m;
        bus.time_valid = 1'b1;
        @(negedge clk);
        bus.time_valid = 1'b0;
        er = 0;
        es = '0;
        if (acc) begin
            p = model_place(m == MODE_SLOW, t);
            if (p < DEPTH) begin
                er = p + 1;
                es = DEPTH'(1 << p);
            end
            if (spam) begin
                bus.time_valid = 1'b1;
                bus.time_in = TIME_W'(1);
                bus.stopwatch_mode = m;
            end
            chk({tag, "_ready_find"}, 32'(bus.time_ready), 32'd0);
            chk({tag, "_rv_find"}, 32'(bus.result_valid), 32'd0);
            @(negedge clk);
            chk({tag, "_ready_ins"}, 32'(bus.time_ready), 32'd0);
            chk({tag, "_rv_ins"}, 32'(bus.result_valid), 32'd0);
            @(negedge clk);
            bus.time_valid = 1'b0;
        end
        chk({tag, "_rv"}, 32'(bus.result_valid), 32'd1);
        chk({tag, "_rank"}, 32'(bus.result_rank), 32'(er));
        chk({tag, "_sound"}, 32'(bus.sound_pulse), 32'(es));
        @(negedge clk);
        chk({tag, "_rv_end"}, 32'(bus.result_valid), 32'd0);
        chk({tag, "_sound_end"}, 32'(bus.sound_pulse), 32'd0);
    endtask

    initial begin
        logic [TIME_W-1:0] rt;
        logic [1:0] rm;
        bus.time_in = '0;
        bus.time_valid = 1'b0;
        bus.stopwatch_mode = MODE_FAST;
        bus.clear = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", 32'(bus.time_ready), 32'd1);
        chk("rst_rv", 32'(bus.result_valid), 32'd0);
        chk("rst_rank", 32'(bus.result_rank), 32'd0);
        chk("rst_sound", 32'(bus.sound_pulse), 32'd0);
        check_display("rst");

        sample("f500", 22'd500, MODE_FAST, 1'b0);
        sample("f300", 22'd300, MODE_FAST, 1'b0);
        sample("f400", 22'd400, MODE_FAST, 1'b1);
        check_display("fast3");
        sample("f600", 22'd600, MODE_FAST, 1'b0);
        sample("f350", 22'd350, MODE_FAST, 1'b0);
        check_display("fast_shift");

        sample("s700a", 22'd700, MODE_SLOW, 1'b0);
        sample("s700b", 22'd700, MODE_SLOW, 1'b1);
        check_display("slow_tie");

        sample("m00", 22'd800, 2'b00, 1'b0);
        sample("m11", 22'd800, 2'b11, 1'b0);
        sample("t0", 22'd0, MODE_SLOW, 1'b0);
        check_display("rejects");

        // Clear while the sample is in FIND.
        wait_ready("clr");
        bus.time_in = 22'd100;
        bus.stopwatch_mode = MODE_FAST;
        bus.time_valid = 1'b1;
        @(negedge clk);
        bus.time_valid = 1'b0;
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        fast_q.delete();
        slow_q.delete();
        chk("clr_rv0", 32'(bus.result_valid), 32'd0);
        chk("clr_ready", 32'(bus.time_ready), 32'd1);
        @(negedge clk);
        chk("clr_rv1", 32'(bus.result_valid), 32'd0);
        check_display("clr");

        // Clear and a valid sample together: sample is dropped silently.
        bus.time_in = 22'd55;
        bus.stopwatch_mode = MODE_SLOW;
        bus.time_valid = 1'b1;
        bus.clear = 1'b1;
        @(negedge clk);
        bus.time_valid = 1'b0;
        bus.clear = 1'b0;
        chk("clrv_rv", 32'(bus.result_valid), 32'd0);
        chk("clrv_ready", 32'(bus.time_ready), 32'd1);
        check_display("clrv");

        sample("r1", 22'd42, MODE_SLOW, 1'b0);
        sample("r2", 22'd43, MODE_FAST, 1'b0);

        // Reset while the sample is in INSERT.
        wait_ready("rsti");
        bus.time_in = 22'd9;
        bus.stopwatch_mode = MODE_FAST;
        bus.time_valid = 1'b1;
        @(negedge clk);
        bus.time_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fast_q.delete();
        slow_q.delete();
        chk("rsti_rv", 32'(bus.result_valid), 32'd0);
        chk("rsti_ready", 32'(bus.time_ready), 32'd1);
        @(negedge clk);
        chk("rsti_rv1", 32'(bus.result_valid), 32'd0);
        check_display("rsti");

        for (int i = 0; i < 40; i++) begin
            rt = TIME_W'($urandom_range(0, 40));
            rm = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 && rm != MODE_SLOW)
                rm = MODE_FAST;
            sample($sformatf("rnd%0d", i), rt, rm, 1'($urandom_range(0, 1)));
            if (i % 8 == 7) check_display($sformatf("rnd%0d", i));
        end
        check_display("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ranked_time_board.md
Name: ranked_time_board

Overview:
Parametrised, clocked successor to the stopwatch leaderboard. Keeps two sorted boards of the best DEPTH recorded times:
- fast board: shortest first
- slow board: longest first

New times are accepted through a valid/ready handshake and inserted by a small FSM with per-entry valid bits. The block pulses per-rank sound strobes and drives the seven-segment/LED display path from a rank selector.

Parameters:
TIME_W, 22, width of a time value in stopwatch ticks
DEPTH, 3, entries per board (legal 1..8)
RANK_W, derived, clog2(DEPTH+1); width of rank fields (0 = none)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
time_in  in  TIME_W  completed stopwatch time
time_valid  in  1  time_in offered this cycle
time_ready  out  1  block can accept a time (high only in IDLE)
stopwatch_mode  in  2  01 = slow board, 10 = fast board, 00/11 = ignore sample
clear  in  1  one-cycle request to empty both boards
result_valid  out  1  one-cycle pulse when an accepted sample finishes
result_rank  out  RANK_W  1..DEPTH = placed rank, 0 = not placed
sound_pulse  out  DEPTH  one-hot one-cycle strobe; bit k-1 = placed at rank k
disp_board  in  1  0 = fast, 1 = slow
disp_rank  in  RANK_W  rank to display, 1..DEPTH
leaderboard_number  out  TIME_W  displayed time
disp_entry_valid  out  1  displayed slot holds a time
leaderboard_LED  out  DEPTH  thermometer code of disp_rank
slow_or_fast  out  2  11 = fast shown, 01 = slow shown, 00 = nothing

Behaviour:
- Reset (rst_n low at a clk edge):
  - all entries and valid bits cleared; FSM to IDLE
  - time_ready=1 on the first cycle after reset; result_valid=0, result_rank=0, sound_pulse=0
  - reset mid-insert discards the sample; no result pulse
- FSM states IDLE -> FIND -> INSERT -> IDLE.
- IDLE:
  - time_ready=1
  - accept when time_valid && stopwatch_mode in {01,10} && time_in != 0 && !clear
  - on accept: latch time and board select, go to FIND
  - mode 00/11 or time 0 with time_valid: sample dropped, result_valid pulses next cycle with rank 0, stay in IDLE
- FIND:
  - p = number of valid entries that rank ahead of the new time
    - slow: entry >= new
    - fast: entry <= new
  - ties rank the existing entry ahead (stable order)
  - invalid entries never rank ahead
- INSERT:
  - if p < DEPTH: entries p..DEPTH-2 shift down one slot with their valid bits; the entry in slot DEPTH-1 is dropped; new time written to slot p, valid set
  - result_rank = p+1; sound_pulse bit p = 1
  - if p == DEPTH: board unchanged, result_rank = 0, sound_pulse = 0
  - result_valid = 1 for this one cycle; go to IDLE
- Timing:
  - latency from accept edge to result_valid is 2 cycles
  - time_ready low in FIND and INSERT; max throughput 1 sample per 3 cycles
  - time_valid while time_ready=0 is ignored; producer must hold or re-present
- Clear:
  - in any state, clear empties both boards next edge and forces IDLE
  - an in-flight insert is aborted with no result pulse
  - clear and time_valid in the same cycle: clear wins, sample dropped
- Display (combinational from registers):
  - disp_rank in 1..DEPTH: leaderboard_number = entry[disp_rank-1] if valid, else 0
  - disp_entry_valid = that entry's valid bit
  - leaderboard_LED = lower disp_rank bits set
  - slow_or_fast = 01 for slow, 11 for fast
  - disp_rank 0 or > DEPTH: all display outputs 0, slow_or_fast = 00
  - display shows the new ordering from the cycle after INSERT

Decomposition:
- Package ranked_time_pkg holds:
  - mode encodings MODE_SLOW=2'b01, MODE_FAST=2'b10
  - SOF_FAST=2'b11, SOF_SLOW=2'b01, SOF_NONE=2'b00
  - FSM state enum {IDLE, FIND, INSERT}
- Sub-module rank_board, instantiated twice (fast, slow) under a DESCENDING parameter:
  - entry/valid storage, position count, shift-insert, clear
- Top level holds the FSM, handshake, result/sound outputs and display mux.

Test Plan:
- Reset with rst_n=0 for 2 cycles -> time_ready=1; sound_pulse=0, result_valid=0; all display ranks show 0 with disp_entry_valid=0 and slow_or_fast=11/01 per board.
- Fast mode (DEPTH=3), insert 500, 300, 400 -> result_rank 1, 1, 2; sound_pulse 001, 001, 010; ranks 1..3 show 300, 400, 500; result_valid 2 cycles after each accept.
- Fast board full, insert 600 -> result_rank 0, board unchanged. Insert 350 -> rank 2; board reads 300, 350, 400; 500 dropped.
- Slow mode, insert 700 then 700 -> ranks 1 then 2; slow ranks 1..2 both show 700; leaderboard_LED 001/011; slow_or_fast 01.
- Rejected and ignored samples:
  - mode 00 with time 800 -> result_rank 0, no change
  - time 0 -> result_rank 0
  - time_valid during FIND/INSERT -> ignored, time_ready=0
- Clear during FIND -> no result_valid, both boards empty next cycle. Separately, rst_n low during INSERT -> no pulse, all state cleared.
